// File: rtl/jpeg_bit_unstuffer.sv
// JPEG entropy-coded byte unstuffer: strips 0xFF00 stuffing, reports markers, serialises data MSB-first.
// Optional emitted-bit counter enabled by defining UNSTUFF_BITCNT_EN.
module jpeg_bit_unstuffer #(
    parameter int unsigned BITCNT_WIDTH = 24
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] byte_in,
    input  logic       byte_valid_in,
    output logic       byte_ready_out,
    output logic       serial_out,
    output logic       valid_out,
    output logic [7:0] marker_out,
    output logic       marker_valid_out,
    output logic       halted_out
`ifdef UNSTUFF_BITCNT_EN
    ,
    output logic [BITCNT_WIDTH-1:0] bit_count_out
`endif
);

    typedef enum logic [1:0] {
        S_DATA,
        S_FF,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  marker_q, marker_d;
    logic        marker_valid_q, marker_valid_d;
    logic        hs;

    always_comb begin
        byte_ready_out   = (state_q != S_HALT) && (cnt_q <= 4'd1);
        hs               = byte_valid_in && byte_ready_out;
        serial_out       = sr_q[7];
        valid_out        = (cnt_q != 4'd0);
        marker_out       = marker_q;
        marker_valid_out = marker_valid_q;
        halted_out       = (state_q == S_HALT);
    end

    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        cnt_d          = cnt_q;
        marker_d       = marker_q;
        marker_valid_d = 1'b0;
        if (cnt_q != 4'd0) begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q - 4'd1;
        end
        // A load overrides the shift; at cnt==1 the last old bit is already on serial_out.
        if (hs) begin
            unique case (state_q)
                S_DATA: begin
                    if (byte_in == 8'hFF) begin
                        state_d = S_FF;
                    end else begin
                        sr_d  = byte_in;
                        cnt_d = 4'd8;
                    end
                end
                S_FF: begin
                    if (byte_in == 8'h00) begin
                        sr_d    = 8'hFF;
                        cnt_d   = 4'd8;
                        state_d = S_DATA;
                    end else if (byte_in != 8'hFF) begin
                        marker_d       = byte_in;
                        marker_valid_d = 1'b1;
                        state_d        = (byte_in == 8'hD9) ? S_HALT : S_DATA;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= S_DATA;
            sr_q           <= '0;
            cnt_q          <= '0;
            marker_q       <= '0;
            marker_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            cnt_q          <= cnt_d;
            marker_q       <= marker_d;
            marker_valid_q <= marker_valid_d;
        end
    end

`ifdef UNSTUFF_BITCNT_EN
    logic [BITCNT_WIDTH-1:0] bitcnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bitcnt_q <= '0;
        end else if (cnt_q != 4'd0) begin
            bitcnt_q <= bitcnt_q + BITCNT_WIDTH'(1);
        end
    end

    assign bit_count_out = bitcnt_q;
`endif

endmodule
